// File: rtl/hvac_zone_arbiter.sv
// Shares one heating/cooling plant between NZ room controllers: largest error wins,
// ties rotate, and the compressor is protected by min-on, dead-time and a fairness quantum.
module hvac_zone_arbiter #(
  parameter int NZ        = 4,
  parameter int MIN_ON    = 8,
  parameter int DEAD_TIME = 4,
  parameter int MAX_ON    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RUN,
  input  logic [2*NZ-1:0] req_mode,
  input  logic [3*NZ-1:0] req_delta,
  input  logic [NZ-1:0]   win_open,
  output logic [NZ-1:0]   grant,
  output logic [1:0]      grant_id,
  output logic [1:0]      hvac_mode,
  output logic            preempt
);

  localparam int OW = $clog2(MAX_ON + 1);
  localparam int DW = $clog2(DEAD_TIME + 1);
  localparam logic [OW-1:0] MIN_LAST  = OW'(MIN_ON - 1);
  localparam logic [OW-1:0] MAX_LAST  = OW'(MAX_ON - 1);
  localparam logic [OW-1:0] MAX_SAT   = OW'(MAX_ON);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_TIME - 1);

  typedef enum logic [1:0] {IDLE, ON, DEAD} state_t;

  state_t          state_q, state_d;
  logic [NZ-1:0]   grant_q, grant_d;
  logic [1:0]      grant_id_q, grant_id_d;
  logic [1:0]      hvac_mode_q, hvac_mode_d;
  logic            preempt_q, preempt_d;
  logic [OW-1:0]   on_cnt_q, on_cnt_d;
  logic [DW-1:0]   dead_cnt_q, dead_cnt_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;

  logic [2:0]      delta [NZ];
  logic [NZ-1:0]   elig;
  logic [2:0]      max_d;
  logic            win_found;
  logic [1:0]      win_id;
  int              idx;

  logic [1:0]      own_mode;
  logic            safety, drop, quantum, arb;

  always_comb begin
    for (int i = 0; i < NZ; i++) begin
      delta[i] = req_delta[3*i +: 3];
      elig[i]  = RUN && (req_mode[2*i +: 2] == 2'b01 || req_mode[2*i +: 2] == 2'b10)
                 && !win_open[i];
    end
  end

  // Largest delta first; among equals the first hit scanning up from rr_ptr+1.
  always_comb begin
    max_d     = '0;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int i = 0; i < NZ; i++)
      if (elig[i] && delta[i] > max_d) max_d = delta[i];
    for (int k = 1; k <= NZ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NZ;
      if (!win_found && elig[idx] && delta[idx] == max_d) begin
        win_found = 1'b1;
        win_id    = 2'(idx);
      end
    end
  end

  assign own_mode = req_mode[2*grant_id_q +: 2];
  assign safety   = win_open[grant_id_q] || !RUN;
  // None (00/11) or a heat<->cool flip both differ from the latched mode.
  assign drop     = (own_mode != hvac_mode_q) && (on_cnt_q >= MIN_LAST);
  // >= so a contender arriving after the counter saturated still gets its turn.
  assign quantum  = (on_cnt_q >= MAX_LAST) && |(elig & ~grant_q);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_id_d  = grant_id_q;
    hvac_mode_d = hvac_mode_q;
    preempt_d   = 1'b0;
    on_cnt_d    = on_cnt_q;
    dead_cnt_d  = dead_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    arb         = 1'b0;
    case (state_q)
      IDLE: arb = 1'b1;
      ON: begin
        if (on_cnt_q != MAX_SAT) on_cnt_d = on_cnt_q + 1'b1;
        if (safety || drop || quantum) begin
          state_d     = DEAD;
          grant_d     = '0;
          grant_id_d  = '0;
          hvac_mode_d = 2'b00;
          dead_cnt_d  = '0;
          preempt_d   = quantum && !safety;
        end
      end
      DEAD: begin
        if (dead_cnt_q == DEAD_LAST) begin
          state_d = IDLE;
          arb     = 1'b1;
        end else begin
          dead_cnt_d = dead_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (arb && win_found) begin
      state_d     = ON;
      grant_d     = NZ'(1) << win_id;
      grant_id_d  = win_id;
      hvac_mode_d = req_mode[2*win_id +: 2];
      rr_ptr_d    = win_id;
      on_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_id_q  <= '0;
      hvac_mode_q <= 2'b00;
      preempt_q   <= 1'b0;
      on_cnt_q    <= '0;
      dead_cnt_q  <= '0;
      rr_ptr_q    <= 2'(NZ - 1);
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_id_q  <= grant_id_d;
      hvac_mode_q <= hvac_mode_d;
      preempt_q   <= preempt_d;
      on_cnt_q    <= on_cnt_d;
      dead_cnt_q  <= dead_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign grant     = grant_q;
  assign grant_id  = grant_id_q;
  assign hvac_mode = hvac_mode_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_hvac_zone_arbiter.sv
// Directed bench for hvac_zone_arbiter: latency, min-on, dead time, priority,
// round-robin quantum, window/RUN safety release and asynchronous reset.
module tb_hvac_zone_arbiter;
  localparam int NZ = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            RUN;
  logic [2*NZ-1:0] req_mode;
  logic [3*NZ-1:0] req_delta;
  logic [NZ-1:0]   win_open;
  logic [NZ-1:0]   grant;
  logic [1:0]      grant_id;
  logic [1:0]      hvac_mode;
  logic            preempt;

  int n_cmp = 0;
  int n_err = 0;
  int n;

  hvac_zone_arbiter #(.NZ(NZ), .MIN_ON(8), .DEAD_TIME(4), .MAX_ON(32)) dut (
    .clk(clk), .rst(rst), .RUN(RUN), .req_mode(req_mode), .req_delta(req_delta),
    .win_open(win_open), .grant(grant), .grant_id(grant_id), .hvac_mode(hvac_mode),
    .preempt(preempt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_zone(input int z, input logic [1:0] m, input logic [2:0] d);
    req_mode[2*z +: 2]  = m;
    req_delta[3*z +: 3] = d;
  endtask

  // Number of consecutive sampled cycles with the plant granted, current one included.
  task automatic count_high(input int lim, output int cnt);
    cnt = 0;
    while (grant != '0 && cnt < lim) begin
      cnt++;
      tick();
    end
  endtask

  task automatic count_off(input int lim, output int cnt);
    cnt = 0;
    while (grant == '0 && cnt < lim) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; RUN = 1'b1; req_mode = '0; req_delta = '0; win_open = '0;
    set_zone(1, 2'b01, 3'd5);
    #2;
    chk("rst_grant", grant, 0);
    chk("rst_id", grant_id, 0);
    chk("rst_mode", hvac_mode, 0);
    chk("rst_preempt", preempt, 0);
    #11 rst = 1'b0;
    tick();
    chk("t1_grant", grant, 4'b0010);
    chk("t1_id", grant_id, 1);
    chk("t1_mode", hvac_mode, 2'b01);
    set_zone(1, 2'b00, 3'd0);
    count_high(40, n);
    chk("t1_len_min_on", n, 8);
    chk("t1_mode_off", hvac_mode, 0);

    // Zone0 held two cycles then dropped: still exactly MIN_ON.
    repeat (6) tick();
    set_zone(0, 2'b01, 3'd2);
    tick();
    chk("t2_grant", grant, 4'b0001);
    chk("t2_mode", hvac_mode, 2'b01);
    tick();
    set_zone(0, 2'b00, 3'd0);
    count_high(40, n);
    chk("t2_len_min_on", n + 1, 8);
    count_off(10, n);
    chk("t2_stays_idle", n, 10);

    // Priority by delta, then dead gap before the loser gets its turn.
    set_zone(0, 2'b01, 3'd3);
    set_zone(2, 2'b10, 3'd6);
    tick();
    chk("t3_grant", grant, 4'b0100);
    chk("t3_id", grant_id, 2);
    chk("t3_mode", hvac_mode, 2'b10);
    repeat (9) tick();
    set_zone(2, 2'b00, 3'd0);
    count_high(40, n);
    chk("t3_tail", n, 1);
    count_off(40, n);
    chk("t3_dead_len", n, 4);
    chk("t3_next_grant", grant, 4'b0001);
    chk("t3_next_mode", hvac_mode, 2'b01);
    chk("t3_next_id", grant_id, 0);
    set_zone(0, 2'b00, 3'd0);
    count_high(40, n);
    chk("t3_z0_len", n, 8);
    count_off(6, n);

    // Equal deltas on zones 0 and 3; rr_ptr is 0, so zone3 goes first.
    set_zone(0, 2'b01, 3'd4);
    set_zone(3, 2'b01, 3'd4);
    tick();
    chk("t4_first", grant, 4'b1000);
    chk("t4_first_id", grant_id, 3);
    count_high(40, n);
    chk("t4_slice1", n, 32);
    chk("t4_preempt1", preempt, 1);
    tick();
    chk("t4_preempt1_clr", preempt, 0);
    count_off(40, n);
    chk("t4_gap1", n + 1, 4);
    chk("t4_second", grant, 4'b0001);
    count_high(40, n);
    chk("t4_slice2", n, 32);
    chk("t4_preempt2", preempt, 1);
    tick();
    count_off(40, n);
    chk("t4_gap2", n + 1, 4);
    chk("t4_third", grant, 4'b1000);
    set_zone(0, 2'b00, 3'd0);
    set_zone(3, 2'b00, 3'd0);
    count_high(40, n);
    chk("t4_drop_len", n, 8);
    chk("t4_drop_nopreempt", preempt, 0);
    count_off(6, n);

    // Window opens at grant cycle 3: immediate release, no preempt.
    set_zone(2, 2'b01, 3'd5);
    tick();
    chk("t5_grant", grant, 4'b0100);
    tick();
    tick();
    win_open[2] = 1'b1;
    set_zone(1, 2'b10, 3'd1);
    tick();
    chk("t5_release", grant, 0);
    chk("t5_preempt", preempt, 0);
    chk("t5_mode_off", hvac_mode, 0);
    count_off(40, n);
    chk("t5_dead_len", n, 4);
    chk("t5_z1_grant", grant, 4'b0010);
    chk("t5_z1_mode", hvac_mode, 2'b10);
    set_zone(1, 2'b00, 3'd0);
    count_high(40, n);
    chk("t5_z1_len", n, 8);
    count_off(12, n);
    chk("t5_win_blocks", n, 12);
    win_open[2] = 1'b0;
    tick();
    chk("t5_regrant", grant, 4'b0100);
    chk("t5_regrant_id", grant_id, 2);

    // Reset mid-grant clears outputs without a clock edge.
    #2 rst = 1'b1;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_mode", hvac_mode, 0);
    chk("arst_id", grant_id, 0);
    rst = 1'b0;
    tick();
    chk("arst_regrant", grant, 4'b0100);

    // RUN drops mid-grant, then reset during DEAD, RUN stays low.
    tick();
    tick();
    RUN = 1'b0;
    tick();
    chk("t6_run_release", grant, 0);
    chk("t6_mode_off", hvac_mode, 0);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_mode", hvac_mode, 0);
    chk("t6_rst_preempt", preempt, 0);
    #2 rst = 1'b0;
    count_off(6, n);
    chk("t6_run_off_idle", n, 6);
    RUN = 1'b1;
    tick();
    chk("t6_run_on_grant", grant, 4'b0100);
    chk("t6_run_on_id", grant_id, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
